// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the multicycle control FSM and the data
// memory bus. Converts dmem_rd/dmem_we strobes into a single valid/ready
// transaction, lane-shifts store data and byte enables, and aligns and extends
// load data before pulsing done.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no bus cycle, err=1). Left undefined, the offending low address
// bits are forced to zero and the access proceeds.
module dmem_lsu #(
   parameter int ADDR_W   = 32,
   parameter int WAIT_MAX = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              dmem_rd,
   input  logic [3:0]        dmem_we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [1:0]        load_size,
   input  logic              load_sign,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic [1:0]       off_q;
   logic [1:0]       size_q;
   logic             sign_q;

   logic             start;
   logic             is_store;
   logic             store_bad;
   logic             load_bad;
   logic             fault;
   logic [1:0]       req_size;
   logic [1:0]       eff_off;
   logic [31:0]      store_word;
   logic [31:0]      load_shifted;
   logic [31:0]      load_result;
   logic             timeout;

   // Decode the incoming request: size, legality, effective lane offset
   always_comb begin
      start     = dmem_rd | (|dmem_we);
      is_store  = |dmem_we;
      store_bad = is_store && !((dmem_we == 4'b0001) || (dmem_we == 4'b0011) ||
                                (dmem_we == 4'b1111));
      load_bad  = !is_store && (load_size == 2'b11);
      req_size  = load_size;
      if (is_store) begin
         if (dmem_we == 4'b0001)
            req_size = 2'b00;
         else if (dmem_we == 4'b0011)
            req_size = 2'b01;
         else
            req_size = 2'b10;
      end
      eff_off = addr[1:0];
      if (req_size == 2'b01)
         eff_off = {addr[1], 1'b0};
      else if (req_size == 2'b10)
         eff_off = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
      fault = store_bad || load_bad ||
              ((req_size == 2'b01) && addr[0]) ||
              ((req_size == 2'b10) && (addr[1:0] != 2'b00));
`else
      fault = store_bad || load_bad;
`endif
      store_word = wdata;
      if (req_size == 2'b00)
         store_word = {4{wdata[7:0]}};
      else if (req_size == 2'b01)
         store_word = {2{wdata[15:0]}};
   end

   // Align the returned bus word to the addressed lane and extend it
   always_comb begin
      load_shifted = mem_rdata >> {off_q, 3'b000};
      case (size_q)
         2'b00:   load_result = sign_q ? {{24{load_shifted[7]}}, load_shifted[7:0]}
                                       : {24'h0, load_shifted[7:0]};
         2'b01:   load_result = sign_q ? {{16{load_shifted[15]}}, load_shifted[15:0]}
                                       : {16'h0, load_shifted[15:0]};
         default: load_result = load_shifted;
      endcase
      timeout = (wait_cnt == CNT_LAST);
   end

   // State register; async reset abandons any transfer in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic and state-derived handshake outputs
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      mem_req    = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               next_state = fault ? DONE : ACCESS;
         end
         ACCESS: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            if (mem_ready || timeout)
               next_state = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Capture the request at start, hold bus fields stable, latch the result
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wait_cnt  <= '0;
         off_q     <= 2'b00;
         size_q    <= 2'b00;
         sign_q    <= 1'b0;
         rdata     <= 32'h0;
         err       <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'h0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  wait_cnt  <= '0;
                  off_q     <= eff_off;
                  size_q    <= req_size;
                  sign_q    <= load_sign;
                  err       <= fault;
                  mem_we    <= is_store;
                  mem_be    <= is_store ? (dmem_we << eff_off) : 4'hF;
                  mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  mem_wdata <= store_word;
                  if (fault)
                     rdata <= 32'h0;
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  if (!mem_we)
                     rdata <= load_result;
               end else if (timeout) begin
                  err   <= 1'b1;
                  rdata <= 32'h0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
